// File: rtl/lc4_regfile_dump_pkg.sv
// Shared definitions for the LC4 register-file dump sequencer: state encoding,
// register count and a small mask helper.
package lc4_regfile_dump_pkg;

  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // True when no bit of mask is set strictly above pos.
  function automatic logic none_above(input logic [NREGS-1:0] mask, input logic [2:0] pos);
    logic [NREGS-1:0] sh;
    sh = mask >> pos;
    return (sh[NREGS-1:1] == '0);
  endfunction

endpackage

// File: rtl/Nbit_reg.sv
// Generic LC4 state register: synchronous reset wins over everything, otherwise
// loads only when both the local and the global write enables are high.
module Nbit_reg #(
  parameter int n = 1,
  parameter logic [n-1:0] r = '0
) (
  input  logic [n-1:0] in,
  output logic [n-1:0] out,
  input  logic         clk,
  input  logic         we,
  input  logic         gwe,
  input  logic         rst
);

  logic [n-1:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= r;
    end else if (gwe & we) begin
      state <= in;
    end
  end

  assign out = state;

endmodule

// File: rtl/lc4_next_set_bit.sv
// Combinational search for the lowest set mask bit above pos; with incl=1 the
// bit at pos itself also qualifies (used to find the first register of a dump).
module lc4_next_set_bit
  import lc4_regfile_dump_pkg::*;
(
  input  logic [NREGS-1:0] mask,
  input  logic [2:0]       pos,
  input  logic             incl,
  output logic [2:0]       nxt,
  output logic             found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    // Descending scan so the last hit written is the lowest qualifying bit.
    for (int k = NREGS - 1; k >= 0; k--) begin
      if (mask[k] && ((3'(k) > pos) || (incl && (3'(k) == pos)))) begin
        nxt   = 3'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc4_regfile_dump.sv
// Read-side sequencer that walks a latched subset of R0..R7 through the rt read
// port and streams the values out on a valid/ready interface.
module lc4_regfile_dump
  import lc4_regfile_dump_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         i_start,
  input  logic [7:0]   i_mask,
  output logic         o_busy,
  output logic [2:0]   o_rsel,
  input  logic [n-1:0] i_rdata,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [n-1:0] o_data,
  output logic [2:0]   o_idx,
  output logic         o_last,
  output logic         o_done
);

  state_t       state_q, state_d;
  logic [1:0]   state_raw;
  logic [7:0]   mask_q, mask_d;
  logic [2:0]   ptr_q, ptr_d;
  logic         valid_d, last_d, done_d;
  logic [n-1:0] data_d;
  logic [2:0]   idx_d;

  logic [2:0]   first_idx, nxt_idx;
  logic         first_found, nxt_found;
  logic         hs;

  Nbit_reg #(.n(2), .r(IDLE)) state_reg (
    .in(state_d), .out(state_raw), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(8)) mask_reg (
    .in(mask_d), .out(mask_q), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(3)) ptr_reg (
    .in(ptr_d), .out(ptr_q), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(1)) valid_reg (
    .in(valid_d), .out(o_valid), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(n)) data_reg (
    .in(data_d), .out(o_data), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(3)) idx_reg (
    .in(idx_d), .out(o_idx), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(1)) last_reg (
    .in(last_d), .out(o_last), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));
  Nbit_reg #(.n(1)) done_reg (
    .in(done_d), .out(o_done), .clk(clk), .we(1'b1), .gwe(gwe), .rst(rst));

  assign state_q = state_t'(state_raw);
  assign o_busy  = (state_q != IDLE);
  assign hs      = o_valid & i_ready;

  // First register of a new request, searched on the live i_mask.
  lc4_next_set_bit first_search (
    .mask(i_mask), .pos(3'd0), .incl(1'b1), .nxt(first_idx), .found(first_found));

  // Next register after the one currently held on the output.
  lc4_next_set_bit next_search (
    .mask(mask_q), .pos(ptr_q), .incl(1'b0), .nxt(nxt_idx), .found(nxt_found));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    valid_d = o_valid;
    data_d  = o_data;
    idx_d   = o_idx;
    last_d  = o_last;
    done_d  = 1'b0;
    o_rsel  = ptr_q;

    case (state_q)
      IDLE: begin
        o_rsel = 3'd0;
        if (i_start) begin
          if (first_found) begin
            mask_d  = i_mask;
            ptr_d   = first_idx;
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      LOAD: begin
        data_d  = i_rdata;
        idx_d   = ptr_q;
        valid_d = 1'b1;
        last_d  = ~nxt_found;
        state_d = SEND;
      end

      SEND: begin
        if (hs) begin
          if (!o_last) begin
            // Steer the read port to the next register now so a new word
            // is captured on the same edge that retires the current one.
            o_rsel = nxt_idx;
            data_d = i_rdata;
            idx_d  = nxt_idx;
            ptr_d  = nxt_idx;
            last_d = none_above(mask_q, nxt_idx);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lc4_regfile_dump.sv
// Randomised bench for lc4_regfile_dump against a transaction-level model: a
// queue of expected register indices, a busy flag and a done flag per dump.
module tb_lc4_regfile_dump;

  logic        clk = 1'b0;
  logic        rst, gwe, i_start, i_ready;
  logic [7:0]  i_mask;
  logic [15:0] i_rdata;
  logic        o_busy, o_valid, o_last, o_done;
  logic [2:0]  o_rsel, o_idx;
  logic [15:0] o_data;

  logic [15:0] rf [8];

  int checks = 0;
  int errors = 0;

  lc4_regfile_dump #(.n(16)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .i_start(i_start), .i_mask(i_mask),
    .o_busy(o_busy), .o_rsel(o_rsel), .i_rdata(i_rdata), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
    .o_done(o_done));

  always #5 clk = ~clk;

  assign i_rdata = rf[o_rsel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // gwe_mode: 0 always enabled, 1 random stalls. pause_at>0 forces gwe=0 for 3 cycles.
  // rst_after>=0 aborts the dump with a reset after that many accepted words.
  task automatic run_dump(input logic [7:0] mask, input int ready_mode, input int gwe_mode,
                          input int pause_at, input int rst_after);
    int          q[$];
    bit          busy_exp, done_exp, seen_valid, prev_hold, hs, last_word;
    logic [15:0] prev_data;
    logic [2:0]  prev_idx;
    logic        prev_last;
    int          edges, accepted;
    busy_exp = 0; done_exp = 0; seen_valid = 0; prev_hold = 0;
    prev_data = '0; prev_idx = '0; prev_last = 0;
    edges = 0; accepted = 0;
    for (int k = 0; k < 8; k++) if (mask[k]) q.push_back(k);

    @(posedge clk); #1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 0) begin
        i_start = 1'b1;
        i_mask  = mask;
        gwe     = 1'b1;
      end else begin
        i_start = (q.size() != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        i_mask  = 8'($urandom);
        gwe     = (gwe_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pause_at > 0 && cyc >= pause_at && cyc < pause_at + 3) gwe = 1'b0;
      end
      case (ready_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 3 == 0);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      chk("busy", 32'(o_busy), 32'(busy_exp));
      chk("done", 32'(o_done), 32'(done_exp));
      if (prev_hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(prev_data));
        chk("hold_idx", 32'(o_idx), 32'(prev_idx));
        chk("hold_last", 32'(o_last), 32'(prev_last));
      end
      if (o_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          chk("latency", 32'(edges), 32'd2);
        end
        if (q.size() == 0) begin
          chk("extra_word", 32'(o_valid), 32'd0);
        end else begin
          chk("idx", 32'(o_idx), 32'(q[0]));
          chk("data", 32'(o_data), 32'(rf[q[0]]));
          chk("last", 32'(o_last), 32'(q.size() == 1));
        end
      end
      hs        = o_valid && i_ready && gwe;
      last_word = hs && (q.size() == 1);
      prev_hold = o_valid && !hs;
      prev_data = o_data;
      prev_idx  = o_idx;
      prev_last = o_last;

      @(posedge clk);
      if (gwe) begin
        edges++;
        done_exp = last_word || (cyc == 0 && mask == 8'h00);
        if (hs && q.size() != 0) begin
          void'(q.pop_front());
          accepted++;
        end
        if (cyc == 0 && mask != 8'h00) busy_exp = 1;
        if (last_word) busy_exp = 0;
      end
      #1;
      if (rst_after >= 0 && accepted == rst_after) break;
      if (cyc > 0 && q.size() == 0 && !busy_exp && !done_exp) break;
    end

    i_start = 1'b0;
    if (rst_after >= 0) begin
      rst = 1'b1;
      gwe = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      gwe = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
    end else begin
      chk("words_left", 32'(q.size()), 32'd0);
      gwe = 1'b1;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk("post_valid", 32'(o_valid), 32'd0);
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("idle_rsel", 32'(o_rsel), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; gwe = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_mask = 8'h00;
    for (int k = 0; k < 8; k++) rf[k] = 16'h1000 + 16'(k);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gwe = 1'b1;
    @(negedge clk);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_idx", 32'(o_idx), 32'd0);
    chk("reset_last", 32'(o_last), 32'd0);
    chk("reset_rsel", 32'(o_rsel), 32'd0);

    run_dump(8'hFF, 0, 0, 0, -1);
    run_dump(8'b1010_0100, 0, 0, 0, -1);
    run_dump(8'hFF, 1, 0, 0, -1);
    run_dump(8'h00, 0, 0, 1, -1);
    run_dump(8'hFF, 0, 0, 5, -1);
    run_dump(8'hFF, 0, 0, 0, 3);
    run_dump(8'b0110_1000, 2, 0, 0, -1);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
      run_dump(8'($urandom), 2, 1, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
